led_display_ctrl: RTL and testbench

Owns the 8-bit LED bank and shares it between three requesters: an ADC level meter fed from the AXI-Stream ADC path, a software pattern override, and a heartbeat blinker. The meter computes a bar graph with peak-hold and timed decay. A priority state machine selects which source drives `led_out`. It sits beside the ADC stream tap and drives the board LED pins directly.

---
 rtl/led_display_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_led_display_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_display_ctrl.sv
// LED bank owner: software pattern beats the ADC level meter, which beats the heartbeat.
// Define LED_DISP_PEAK_DOT_EN to show the instantaneous bar plus a peak dot instead of the held bar.
module led_display_ctrl #(
  parameter int ADC_WIDTH        = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BIT_OFFSET       = 0,
  parameter int HOLD_CYCLES      = 12500000,
  parameter int DECAY_CYCLES     = 1250000,
  parameter int IDLE_CYCLES      = 1250000,
  parameter int BLINK_CYCLES     = 62500000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  output logic                        S_AXIS_tready,
  input  logic                        sw_req,
  input  logic [7:0]                  sw_pattern,
  output logic                        sw_grant,
  output logic [1:0]                  mode,
  output logic [7:0]                  led_out
);

  localparam int W       = ADC_WIDTH - BIT_OFFSET;
  localparam int MAX_HD  = (HOLD_CYCLES > DECAY_CYCLES) ? HOLD_CYCLES : DECAY_CYCLES;
  localparam int MAX_IB  = (IDLE_CYCLES > BLINK_CYCLES) ? IDLE_CYCLES : BLINK_CYCLES;
  localparam int MAX_CYC = (MAX_HD > MAX_IB) ? MAX_HD : MAX_IB;
  localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DECAY_LOAD = CNT_W'(DECAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD  = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);
  localparam logic [W-2:0]     MAG_ONE    = (W-1)'(1);

  typedef enum logic [1:0] {HB = 2'd0, METER = 2'd1, SW = 2'd2} state_t;

  state_t           state_reg;
  logic [W-1:0]     sample;
  logic [W-2:0]     mag;
  logic [3:0]       level_now;
  logic [3:0]       peak_reg;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] decay_cnt;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;
  logic             stream_active;
  logic [7:0]       meter_leds;
  logic             unused_tdata;

  function automatic logic [7:0] bar(input logic [3:0] n);
    return 8'hFF >> (4'd8 - n);
  endfunction

  assign S_AXIS_tready = 1'b1;
  assign sample        = S_AXIS_tdata[W-1:0];
  assign unused_tdata  = ^S_AXIS_tdata[AXIS_TDATA_WIDTH-1:W];
  assign stream_active = S_AXIS_tvalid | (idle_cnt != '0);

  // Most-negative code has no positive twin, so it saturates to full scale.
  always_comb begin
    if (!sample[W-1])
      mag = sample[W-2:0];
    else if (sample[W-2:0] == '0)
      mag = '1;
    else
      mag = ~sample[W-2:0] + MAG_ONE;
    level_now = (mag == '0) ? 4'd0 : ({1'b0, mag[W-2:W-4]} + 4'd1);
  end

`ifdef LED_DISP_PEAK_DOT_EN
  logic [3:0] level_reg;

  always_ff @(posedge clk) begin
    if (!rst)
      level_reg <= 4'd0;
    else if (S_AXIS_tvalid)
      level_reg <= level_now;
  end

  always_comb begin
    meter_leds = bar(level_reg);
    if (peak_reg != 4'd0)
      meter_leds = meter_leds | (8'h01 << (peak_reg - 4'd1));
  end
`else
  always_comb begin
    meter_leds = bar(peak_reg);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst)
      idle_cnt <= '0;
    else if (S_AXIS_tvalid)
      idle_cnt <= IDLE_LOAD;
    else if (idle_cnt != '0)
      idle_cnt <= idle_cnt - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= HB;
      mode        <= 2'd0;
      sw_grant    <= 1'b0;
      led_out     <= 8'hFF;
      peak_reg    <= 4'd0;
      hold_cnt    <= '0;
      decay_cnt   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      // Peak hold: a new or equal level refreshes the hold window, then decay one step at a time.
      if (S_AXIS_tvalid && ((level_now > peak_reg) ||
                            ((level_now == peak_reg) && (peak_reg != 4'd0)))) begin
        peak_reg  <= level_now;
        hold_cnt  <= HOLD_LOAD;
        decay_cnt <= '0;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - CNT_ONE;
      end else if (peak_reg != 4'd0) begin
        if (decay_cnt == '0) begin
          peak_reg  <= peak_reg - 4'd1;
          decay_cnt <= DECAY_LOAD;
        end else begin
          decay_cnt <= decay_cnt - CNT_ONE;
        end
      end

      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + CNT_ONE;
      end

      case (state_reg)
        HB:      led_out <= blink_phase ? 8'h00 : 8'h01;
        METER:   led_out <= meter_leds;
        default: led_out <= sw_pattern;
      endcase

      // Transitions into HB override the peak and blink updates above.
      case (state_reg)
        HB: begin
          if (sw_req) begin
            state_reg <= SW;
            mode      <= 2'd2;
            sw_grant  <= 1'b1;
          end else if (stream_active) begin
            state_reg <= METER;
            mode      <= 2'd1;
            sw_grant  <= 1'b0;
          end
        end
        METER: begin
          if (sw_req) begin
            state_reg <= SW;
            mode      <= 2'd2;
            sw_grant  <= 1'b1;
          end else if (!stream_active) begin
            state_reg   <= HB;
            mode        <= 2'd0;
            sw_grant    <= 1'b0;
            peak_reg    <= 4'd0;
            hold_cnt    <= '0;
            decay_cnt   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
          end
        end
        default: begin
          if (!sw_req) begin
            if (stream_active) begin
              state_reg <= METER;
              mode      <= 2'd1;
              sw_grant  <= 1'b0;
            end else begin
              state_reg   <= HB;
              mode        <= 2'd0;
              sw_grant    <= 1'b0;
              peak_reg    <= 4'd0;
              hold_cnt    <= '0;
              decay_cnt   <= '0;
              blink_cnt   <= '0;
              blink_phase <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_display_ctrl.sv
// Randomized and directed bench for led_display_ctrl; two instances (W=14 and W=10) share one stimulus.
module tb_led_display_ctrl;

  localparam int HOLD  = 8;
  localparam int DECAY = 4;
  localparam int IDLE  = 16;
  localparam int BLINK = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] tdata = 32'h0;
  logic        tvalid = 1'b0;
  logic        sw_req = 1'b0;
  logic [7:0]  sw_pattern = 8'h00;

  logic       tready_a, tready_b, grant_a, grant_b;
  logic [1:0] mode_a, mode_b;
  logic [7:0] led_a, led_b;

  always #5 clk = ~clk;

  led_display_ctrl #(
    .ADC_WIDTH(14), .AXIS_TDATA_WIDTH(32), .BIT_OFFSET(0),
    .HOLD_CYCLES(HOLD), .DECAY_CYCLES(DECAY), .IDLE_CYCLES(IDLE), .BLINK_CYCLES(BLINK)
  ) dut_w14 (
    .clk(clk), .rst(rst), .S_AXIS_tdata(tdata), .S_AXIS_tvalid(tvalid),
    .S_AXIS_tready(tready_a), .sw_req(sw_req), .sw_pattern(sw_pattern),
    .sw_grant(grant_a), .mode(mode_a), .led_out(led_a)
  );

  led_display_ctrl #(
    .ADC_WIDTH(14), .AXIS_TDATA_WIDTH(32), .BIT_OFFSET(4),
    .HOLD_CYCLES(HOLD), .DECAY_CYCLES(DECAY), .IDLE_CYCLES(IDLE), .BLINK_CYCLES(BLINK)
  ) dut_w10 (
    .clk(clk), .rst(rst), .S_AXIS_tdata(tdata), .S_AXIS_tvalid(tvalid),
    .S_AXIS_tready(tready_b), .sw_req(sw_req), .sw_pattern(sw_pattern),
    .sw_grant(grant_b), .mode(mode_b), .led_out(led_b)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: owner 0=HB 1=METER 2=SW, peak as (value, time of last refresh).
  int cyc = 0;
  int owner = 0;
  int hb_entry = 0;
  int last_valid = -100000;
  int wid[2] = '{14, 10};
  int pk_val[2] = '{0, 0};
  int pk_time[2] = '{0, 0};
  int lvl[2] = '{0, 0};
  int exp_led[2] = '{255, 255};

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int level_of(input logic [31:0] d, input int w);
    int x, v, mag;
    x = int'(d & ((32'h1 << w) - 32'h1));
    v = (x >= (1 << (w - 1))) ? x - (1 << w) : x;
    mag = (v < 0) ? -v : v;
    if (mag > (1 << (w - 1)) - 1) mag = (1 << (w - 1)) - 1;
    return (mag == 0) ? 0 : (mag >> (w - 4)) + 1;
  endfunction

  function automatic int peak_at(input int i, input int t);
    int d, p;
    d = t - pk_time[i];
    if (d < HOLD) return pk_val[i];
    p = pk_val[i] - 1 - (d - HOLD) / DECAY;
    return (p < 0) ? 0 : p;
  endfunction

  function automatic int meter_view(input int i);
    int p, v;
    p = peak_at(i, cyc - 1);
`ifdef LED_DISP_PEAK_DOT_EN
    v = (1 << lvl[i]) - 1;
    if (p > 0) v = v | (1 << (p - 1));
`else
    v = (1 << p) - 1;
`endif
    return v;
  endfunction

  task automatic model_step();
    int nxt, l, cur;
    bit active;
    if (!rst) begin
      owner = 0;
      hb_entry = cyc;
      last_valid = -100000;
      for (int i = 0; i < 2; i++) begin
        pk_val[i] = 0; pk_time[i] = cyc; lvl[i] = 0; exp_led[i] = 8'hFF;
      end
    end else begin
      active = tvalid || (cyc - last_valid < IDLE);
      for (int i = 0; i < 2; i++) begin
        if (owner == 0) exp_led[i] = (((cyc - hb_entry - 1) / BLINK) % 2 == 0) ? 1 : 0;
        else if (owner == 1) exp_led[i] = meter_view(i);
        else exp_led[i] = sw_pattern;
        if (tvalid) begin
          l = level_of(tdata, wid[i]);
          cur = peak_at(i, cyc - 1);
          if (l > cur || (l == cur && cur != 0)) begin
            pk_val[i] = l; pk_time[i] = cyc;
          end
          lvl[i] = l;
        end
      end
      if (tvalid) last_valid = cyc;
      nxt = sw_req ? 2 : (active ? 1 : 0);
      if (nxt == 0 && owner != 0) begin
        hb_entry = cyc;
        for (int i = 0; i < 2; i++) begin
          pk_val[i] = 0; pk_time[i] = cyc;
        end
      end
      owner = nxt;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check_eq("led_w14", led_a, exp_led[0]);
    check_eq("led_w10", led_b, exp_led[1]);
    check_eq("mode_w14", mode_a, owner);
    check_eq("mode_w10", mode_b, owner);
    check_eq("grant_w14", grant_a, (owner == 2) ? 1 : 0);
    check_eq("grant_w10", grant_b, (owner == 2) ? 1 : 0);
    check_eq("tready", {tready_a, tready_b}, 3);
  endtask

  task automatic send(input logic [31:0] v);
    tdata = v;
    tvalid = 1'b1;
    tick();
    tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  int dens_tab[4] = '{0, 6, 40, 95};

  initial begin
    $display("reset: rst low for 3 cycles, then heartbeat");
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(12);

    $display("level mapping: +0x1000, -0x2000, 0 with short gaps");
    send(32'h0000_1000); idle(5);
    send(32'hFFFF_E000); idle(10);
    send(32'h0000_0000); idle(12);
    send(32'h0000_0000); idle(20);

    $display("peak dot: 0x2000 once then 0x0400 continuous");
    send(32'h0000_2000);
    tdata = 32'h0000_0400;
    tvalid = 1'b1;
    idle(30);

    $display("software override with stream active");
    sw_pattern = 8'hA5;
    sw_req = 1'b1;
    idle(4);
    sw_pattern = 8'h3C;
    idle(3);
    sw_req = 1'b0;
    idle(4);

    $display("idle timeout back to heartbeat");
    tvalid = 1'b0;
    idle(20);

    $display("sw_req on the timeout cycle");
    send(32'h0000_1000); idle(15);
    sw_req = 1'b1; tick();
    sw_req = 1'b0; idle(8);

    $display("tvalid on the timeout cycle");
    send(32'h0000_1000); idle(15);
    send(32'h0000_0800); idle(20);

    $display("reset in the middle of metering");
    tdata = 32'h0000_1800;
    tvalid = 1'b1;
    idle(5);
    rst = 1'b0; idle(2);
    rst = 1'b1;
    tvalid = 1'b0;
    idle(10);

    $display("narrow field sample 0x01FF");
    send(32'h0000_01FF); idle(12);
    send(32'h0000_0200); idle(20);

    $display("randomized traffic");
    for (int blk = 0; blk < 12; blk++) begin
      int dens;
      dens = dens_tab[blk % 4];
      for (int n = 0; n < 150; n++) begin
        rst = ($urandom_range(0, 499) != 0);
        if ($urandom_range(0, 99) < 4) sw_req = ~sw_req;
        sw_pattern = 8'($urandom);
        tvalid = ($urandom_range(0, 99) < dens);
        case ($urandom_range(0, 5))
          0: tdata = 32'h0000_0000;
          1: tdata = 32'h0000_2000;
          2: tdata = 32'h0000_0200;
          default: tdata = $urandom;
        endcase
        tick();
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
